// File: rtl/mul_pipe_hs.sv
// mul_pipe_hs: pipelined multiplier with a valid/ready handshake.
// S1 registers the operands, S2 the full-width product, S3..S(N-1) delay it,
// and SN holds the shifted, narrowed result with its overflow flag.
// Every stage advances together, so a stalled output holds the whole pipe.
module mul_pipe_hs #(
  parameter int A_WIDTH   = 25,
  parameter int B_WIDTH   = 6,
  parameter int P_WIDTH   = 25,
  parameter int A_SIGNED  = 1,
  parameter int B_SIGNED  = 0,
  parameter int NUM_STAGE = 4,
  parameter int SHIFT     = 0,
  parameter int SAT       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [P_WIDTH-1:0] p,
  output logic               ovf
);

  // Full product width: one extra bit so that unsigned x unsigned and
  // mixed-sign products are always exact as a signed value.
  localparam int PW   = A_WIDTH + B_WIDTH + 1;
  // Product-carrying stages S2..S(N-1).
  localparam int NDLY = NUM_STAGE - 2;
  // Working width for the range check: wide enough for both q and p plus a sign bit.
  localparam int QW   = (PW > P_WIDTH + 1) ? PW : P_WIDTH + 1;
  localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

  if (NUM_STAGE < 3 || NUM_STAGE > 8) begin : g_bad_num_stage
    $error("mul_pipe_hs: NUM_STAGE must be in 3..8");
  end
  if (SHIFT < 0 || SHIFT > A_WIDTH + B_WIDTH - 1) begin : g_bad_shift
    $error("mul_pipe_hs: SHIFT must be in 0..A_WIDTH+B_WIDTH-1");
  end
  if (A_WIDTH < 1 || B_WIDTH < 1 || P_WIDTH < 2) begin : g_bad_width
    $error("mul_pipe_hs: A_WIDTH and B_WIDTH must be >= 1, P_WIDTH >= 2");
  end
  if (A_SIGNED < 0 || A_SIGNED > 1 || B_SIGNED < 0 || B_SIGNED > 1 || SAT < 0 || SAT > 1) begin : g_bad_flag
    $error("mul_pipe_hs: A_SIGNED, B_SIGNED and SAT must be 0 or 1");
  end

  logic [NUM_STAGE:1]       v_q;
  logic [A_WIDTH-1:0]       a_q;
  logic [B_WIDTH-1:0]       b_q;
  logic signed [PW-1:0]     pipe_q [NDLY];
  logic [P_WIDTH-1:0]       p_q;
  logic                     ovf_q;

  logic                     adv;
  logic                     acc;
  logic signed [PW-1:0]     a_ext;
  logic signed [PW-1:0]     b_ext;
  logic signed [PW-1:0]     prod_d;
  logic signed [PW-1:0]     q;
  logic signed [QW-1:0]     q_ext;
  logic signed [QW-1:0]     hi_s;
  logic signed [QW-1:0]     hi_u;
  logic                     fits;
  logic [P_WIDTH-1:0]       bound;
  logic [P_WIDTH-1:0]       p_d;
  logic                     ovf_d;

  assign adv       = !v_q[NUM_STAGE] || out_ready;
  assign acc       = in_valid && adv;
  assign in_ready  = adv;
  assign out_valid = v_q[NUM_STAGE];
  assign p         = p_q;
  assign ovf       = ovf_q;

  // Operand extension and the full-precision product feeding S2.
  always_comb begin
    a_ext = (A_SIGNED != 0) ? {{(PW-A_WIDTH){a_q[A_WIDTH-1]}}, a_q}
                            : {{(PW-A_WIDTH){1'b0}}, a_q};
    b_ext = (B_SIGNED != 0) ? {{(PW-B_WIDTH){b_q[B_WIDTH-1]}}, b_q}
                            : {{(PW-B_WIDTH){1'b0}}, b_q};
    prod_d = a_ext * b_ext;
  end

  // Floor shift of the last delayed product, then range check and narrowing.
  always_comb begin
    q     = pipe_q[NDLY-1] >>> SHIFT;
    q_ext = QW'(q);
    hi_s  = q_ext >>> (P_WIDTH - 1);
    hi_u  = q_ext >>> P_WIDTH;
    fits  = 1'b0;
    bound = '0;
    if (RES_SIGNED) begin
      fits  = (hi_s == '0) || (hi_s == '1);
      bound = q_ext[QW-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                          : {1'b0, {(P_WIDTH-1){1'b1}}};
    end else begin
      fits  = (hi_u == '0);
      bound = q_ext[QW-1] ? '0 : '1;
    end
    ovf_d = !fits;
    p_d   = (fits || SAT == 0) ? q_ext[P_WIDTH-1:0] : bound;
  end

  // Globally stalled pipeline; data registers load only behind a valid bit
  // so bubbles never disturb the held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      for (int i = 0; i < NDLY; i++) pipe_q[i] <= '0;
      p_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q <= {v_q[NUM_STAGE-1:1], acc};
      if (acc) begin
        a_q <= a;
        b_q <= b;
      end
      if (v_q[1]) pipe_q[0] <= prod_d;
      for (int i = 1; i < NDLY; i++) begin
        if (v_q[i+1]) pipe_q[i] <= pipe_q[i-1];
      end
      if (v_q[NUM_STAGE-1]) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Directed bench for mul_pipe_hs: three instances (wrap, saturate, shift-by-4)
// share one stimulus stream; each step checks against hand-computed values.
module tb_mul_pipe_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [24:0] a;
  logic [5:0]  b;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [24:0] p0, p1, p2;
  logic        ovf0, ovf1, ovf2;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;
  int nin, nout, last_c;

  always #5 clk = ~clk;

  mul_pipe_hs u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready), .p(p0), .ovf(ovf0)
  );

  mul_pipe_hs #(.SAT(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready), .p(p1), .ovf(ovf1)
  );

  mul_pipe_hs #(.SHIFT(4)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready), .p(p2), .ovf(ovf2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat, then wait (bounded) until it reaches the output.
  // lat counts edges from the accepting edge to the one that shows out_valid.
  task automatic single(input logic [24:0] av, input logic [5:0] bv, output int l);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    l = 1;
    while (!ov0 && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #1;
    chk("reset_out_valid", 32'(ov0), 32'd0);
    chk("reset_p", 32'(p0), 32'd0);
    chk("reset_ovf", 32'(ovf0), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("idle_in_ready", 32'(rdy0), 32'd1);

    // -3 * 5, latency and signed result
    single(25'h1FFFFFD, 6'd5, lat);
    chk("neg_latency", 32'(lat), 32'd4);
    chk("neg_p", 32'(p0), 32'h1FFFFF1);
    chk("neg_ovf", 32'(ovf0), 32'd0);
    tick();
    chk("single_drained", 32'(ov0), 32'd0);

    // largest positive a times 63: wrap vs saturate
    single(25'd16777215, 6'd63, lat);
    chk("maxpos_wrap_p", 32'(p0), 32'd16777153);
    chk("maxpos_wrap_ovf", 32'(ovf0), 32'd1);
    chk("maxpos_sat_p", 32'(p1), 32'd16777215);
    chk("maxpos_sat_ovf", 32'(ovf1), 32'd1);
    tick();

    // most negative a times 63
    single(25'h1000000, 6'd63, lat);
    chk("minneg_sat_p", 32'(p1), 32'h1000000);
    chk("minneg_sat_ovf", 32'(ovf1), 32'd1);
    chk("minneg_wrap_p", 32'(p0), 32'h1000000);
    chk("minneg_wrap_ovf", 32'(ovf0), 32'd1);
    tick();

    // zero operand
    single(25'd0, 6'd63, lat);
    chk("zero_p", 32'(p0), 32'd0);
    chk("zero_ovf", 32'(ovf0), 32'd0);
    chk("zero_sat_ovf", 32'(ovf1), 32'd0);
    tick();

    // floor shift by 4
    single(25'h1FFFFEF, 6'd1, lat);
    chk("shift_neg_p", 32'(p2), 32'h1FFFFFE);
    chk("shift_neg_ovf", 32'(ovf2), 32'd0);
    tick();
    single(25'd17, 6'd1, lat);
    chk("shift_pos_p", 32'(p2), 32'd1);
    chk("shift_pos_ovf", 32'(ovf2), 32'd0);
    tick();

    // stream 1..8 times 2 with out_ready low in cycles 5..9
    nin    = 0;
    nout   = 0;
    last_c = -1;
    for (int c = 0; c < 40 && nout < 8; c++) begin
      in_valid  = (nin < 8);
      a         = 25'(nin + 1);
      b         = 6'd2;
      out_ready = !(c >= 5 && c <= 9);
      #1;
      if (c >= 5 && c <= 9) begin
        chk("stall_in_ready", 32'(rdy0), 32'd0);
        chk("stall_hold", 32'({ov0, ovf0, p0}), 32'({1'b1, 1'b0, 25'(2 * (nout + 1))}));
      end
      if (ov0 && out_ready) begin
        chk("stream_p", 32'(p0), 32'(2 * (nout + 1)));
        nout++;
        last_c = c;
      end
      if (in_valid && rdy0) nin++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 32'(nout), 32'd8);
    chk("stream_last_cycle", 32'(last_c), 32'd16);

    // three accepts, then an async reset before any result emerges
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a        = 25'(10 + k);
      b        = 6'd3;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midreset_async", 32'({ov0, ovf0, p0}), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("post_reset_quiet", 32'({ov0, ovf0, p0}), 32'd0);
      tick();
    end
    single(25'd7, 6'd9, lat);
    chk("post_reset_latency", 32'(lat), 32'd4);
    chk("post_reset_p", 32'(p0), 32'd63);
    chk("post_reset_ovf", 32'(ovf0), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_pipe_hs.md
Name: mul_pipe_hs

Overview:
- Parametrised pipelined multiplier; successor to the fixed-width, ce-gated HLS multiplier cores.
- Configurable operand and result widths, per-operand signedness and pipeline depth.
- Adds a valid/ready handshake with backpressure, post-product arithmetic right shift, and saturate-or-wrap result narrowing with an overflow flag.
- Used wherever HLS-generated datapaths need a multiplier that can stall without an external ce network.

Parameters:
- A_WIDTH, 25, width of operand a
- B_WIDTH, 6, width of operand b
- P_WIDTH, 25, width of result p
- A_SIGNED, 1, 1 = a is two's complement, 0 = unsigned
- B_SIGNED, 0, 1 = b is two's complement, 0 = unsigned (zero-extended)
- NUM_STAGE, 4, accept-to-output latency in cycles; legal range 3..8
- SHIFT, 0, arithmetic right shift applied to the full product; legal range 0..A_WIDTH+B_WIDTH-1
- SAT, 0, 1 = saturate to the P_WIDTH range, 0 = keep the low P_WIDTH bits (wrap)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-high
- in_valid  in  1  a/b valid
- in_ready  out  1  block can accept this cycle
- a  in  A_WIDTH  operand a
- b  in  B_WIDTH  operand b
- out_valid  out  1  p valid
- out_ready  in  1  downstream accepts p
- p  out  P_WIDTH  result; signed iff A_SIGNED or B_SIGNED
- ovf  out  1  result was saturated (SAT=1) or wrapped (SAT=0); qualified by out_valid

Behaviour:
- Reset is asynchronous, active-high. While reset is asserted:
  - every stage valid bit is 0 and every data register is 0;
  - out_valid=0, p=0, ovf=0.
  - Reset asserted mid-operation discards all in-flight data; nothing is emitted after release.
- The pipeline has NUM_STAGE register stages, each holding a valid bit plus data:
  - S1 registers a and b.
  - S2 holds the full product, width A_WIDTH+B_WIDTH+1, formed after sign/zero extension of each operand per its *_SIGNED parameter.
  - S3..S(N-1) are pure delay stages.
  - SN holds the shifted, narrowed p and ovf.
- Stall rule: adv = !v[N] | out_ready. All stages load only when adv=1; when adv=0 they all hold (global stall). in_ready = adv.
- Accept: an input is taken when in_valid & in_ready. A taken input sets v[1]=1 on the next edge; otherwise v[1] loads 0 when adv=1.
- Valid bits shift v[k] <= v[k-1] when adv=1.
- out_valid = v[N]. Output transfer occurs when out_valid & out_ready.
- Latency: with no stall, a result appears NUM_STAGE cycles after acceptance. Throughput is 1 per cycle.
- Bubbles are not collapsed while stalled; the stall is global.
- Ordering is strictly FIFO. No input is lost or duplicated under any out_ready pattern.
- p, ovf and out_valid hold stable while out_valid=1 and out_ready=0.
- Shift is an arithmetic right shift of the full product by SHIFT, i.e. floor division by 2^SHIFT. Negative values round toward minus infinity.
- Narrowing of the shifted value q to P_WIDTH bits:
  - If q fits the P_WIDTH range (signed or unsigned per the result type), p=q and ovf=0.
  - If q does not fit and SAT=1, p is the nearest range bound and ovf=1.
  - If q does not fit and SAT=0, p is the low P_WIDTH bits of q and ovf=1.
- Simultaneous input accept and output transfer in the same cycle is legal and sustains full throughput.
- in_valid while in_ready=0: inputs are ignored. Upstream must hold a/b stable.
- Illegal parameter values cause an elaboration-time error.

Test Plan (default parameters unless stated):
- a=-3, b=5, single beat, out_ready=1 -> out_valid exactly 4 cycles after accept; p=-15 (0x1FFFFF1); ovf=0.
- a=16777215, b=63, SAT=0 -> p=16777153, ovf=1. Same input with SAT=1 -> p=16777215, ovf=1.
- a=-16777216, b=63, SAT=1 -> p=-16777216 (0x1000000), ovf=1. a=0, b=63 -> p=0, ovf=0.
- SHIFT=4: a=-17, b=1 -> p=-2; a=17, b=1 -> p=1; ovf=0 in both cases.
- Stream a=1..8 with b=2 back-to-back, holding out_ready=0 for 5 cycles mid-stream -> in_ready=0 during the stall; output is 2,4,...,16 in order with no gaps beyond the stall; p is stable while held.
- Accept 3 inputs, assert reset 2 cycles later for 1 cycle -> out_valid stays 0 with p=0 and ovf=0. A new input after release yields the correct result with latency 4.
